// File: rtl/wxyz_skew_feed_nxn.sv
// rtl/wxyz_skew_feed_nxn.sv - diagonally skewed row feeder for the nxn systolic array
//
// Accepts one row per cycle (in_valid/in_ready), frames rows into tiles of
// arraySize rows and emits column j delayed by j+1 cycles.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   interrupt                abort the current frame and flush the skew chains
//   in_valid, in_ready       row handshake; in_ready is combinational from state
//   row_0..row_3             input row elements, element j feeds column j
//   out_valid                accept strobe aligned with col_0 (accumulator valid)
//   col_0..col_3             skewed column data
//   col_valid_0..col_valid_3 per-column valid, skewed like the data
//   frame_last               marks the last row of a frame, aligned with out_valid
//   frame_abort              one-cycle pulse when a frame in progress is aborted
//
// The port list is laid out for arraySize = 4.
module wxyz_skew_feed_nxn #(
    parameter int arraySize    = 4,
    parameter int inputBits    = 8,
    parameter int addressWidth = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 interrupt,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [inputBits-1:0] row_0,
    input  logic [inputBits-1:0] row_1,
    input  logic [inputBits-1:0] row_2,
    input  logic [inputBits-1:0] row_3,
    output logic                 out_valid,
    output logic [inputBits-1:0] col_0,
    output logic [inputBits-1:0] col_1,
    output logic [inputBits-1:0] col_2,
    output logic [inputBits-1:0] col_3,
    output logic                 col_valid_0,
    output logic                 col_valid_1,
    output logic                 col_valid_2,
    output logic                 col_valid_3,
    output logic                 frame_last,
    output logic                 frame_abort
);

    localparam logic [addressWidth-1:0] LAST = addressWidth'(arraySize - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [addressWidth-1:0] row_cnt, row_cnt_next;
    logic [addressWidth-1:0] drain_cnt, drain_cnt_next;
    logic                    abort_next;
    logic                    accept;

    logic [inputBits-1:0]    row_in   [arraySize];
    logic [inputBits-1:0]    col_data [arraySize];
    logic                    col_vld  [arraySize];

    assign row_in[0] = row_0;
    assign row_in[1] = row_1;
    assign row_in[2] = row_2;
    assign row_in[3] = row_3;

    // interrupt blocks the handshake in the same cycle it is raised
    assign in_ready = !rst && !interrupt && (state != DRAIN);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next     = state;
        row_cnt_next   = row_cnt;
        drain_cnt_next = drain_cnt;
        abort_next     = 1'b0;
        if (interrupt) begin
            state_next     = DRAIN;
            row_cnt_next   = '0;
            drain_cnt_next = '0;
            abort_next     = (row_cnt != '0) || (state == FEED);
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        row_cnt_next = (row_cnt == LAST) ? '0 : row_cnt + 1'b1;
                        if (arraySize > 1) state_next = FEED;
                    end
                end
                FEED: begin
                    if (accept) begin
                        row_cnt_next = (row_cnt == LAST) ? '0 : row_cnt + 1'b1;
                    end else if (row_cnt != '0) begin
                        // the accumulator clears on any valid-low cycle, so a
                        // partial frame cannot be resumed
                        abort_next     = 1'b1;
                        row_cnt_next   = '0;
                        drain_cnt_next = '0;
                        state_next     = DRAIN;
                    end else begin
                        state_next = IDLE;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == LAST) begin
                        drain_cnt_next = '0;
                        state_next     = IDLE;
                    end else begin
                        drain_cnt_next = drain_cnt + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            row_cnt     <= '0;
            drain_cnt   <= '0;
            frame_last  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_next;
            row_cnt     <= row_cnt_next;
            drain_cnt   <= drain_cnt_next;
            frame_last  <= accept && (row_cnt == LAST);
            frame_abort <= abort_next;
        end
    end

    // Column j is a chain of j+1 registers; idle cycles shift in zero bubbles.
    for (genvar j = 0; j < arraySize; j++) begin : g_col
        logic [inputBits-1:0] data_q  [j+1];
        logic                 valid_q [j+1];

        always_ff @(posedge clk) begin
            if (rst || interrupt) begin
                for (int k = 0; k <= j; k++) begin
                    data_q[k]  <= '0;
                    valid_q[k] <= 1'b0;
                end
            end else begin
                data_q[0]  <= accept ? row_in[j] : '0;
                valid_q[0] <= accept;
                for (int k = 1; k <= j; k++) begin
                    data_q[k]  <= data_q[k-1];
                    valid_q[k] <= valid_q[k-1];
                end
            end
        end

        assign col_data[j] = data_q[j];
        assign col_vld[j]  = valid_q[j];
    end

    assign col_0       = col_data[0];
    assign col_1       = col_data[1];
    assign col_2       = col_data[2];
    assign col_3       = col_data[3];
    assign col_valid_0 = col_vld[0];
    assign col_valid_1 = col_vld[1];
    assign col_valid_2 = col_vld[2];
    assign col_valid_3 = col_vld[3];
    assign out_valid   = col_vld[0];

endmodule

// File: tb/tb_wxyz_skew_feed_nxn.sv
// tb/tb_wxyz_skew_feed_nxn.sv - scoreboard bench for wxyz_skew_feed_nxn
module tb_wxyz_skew_feed_nxn;

    localparam int N    = 4;
    localparam int MAXC = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       interrupt = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] row_0 = '0, row_1 = '0, row_2 = '0, row_3 = '0;
    logic       out_valid;
    logic [7:0] col_0, col_1, col_2, col_3;
    logic       col_valid_0, col_valid_1, col_valid_2, col_valid_3;
    logic       frame_last, frame_abort;

    wxyz_skew_feed_nxn #(.arraySize(4), .inputBits(8), .addressWidth(2)) dut (
        .clk(clk), .rst(rst), .interrupt(interrupt),
        .in_valid(in_valid), .in_ready(in_ready),
        .row_0(row_0), .row_1(row_1), .row_2(row_2), .row_3(row_3),
        .out_valid(out_valid),
        .col_0(col_0), .col_1(col_1), .col_2(col_2), .col_3(col_3),
        .col_valid_0(col_valid_0), .col_valid_1(col_valid_1),
        .col_valid_2(col_valid_2), .col_valid_3(col_valid_3),
        .frame_last(frame_last), .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          cyc;
        logic [31:0] cols;
        logic [3:0]  cv;
        logic        ov;
        logic        fl;
        logic        fa;
    } exp_t;

    exp_t exp_q[$];

    int n_vec  = 0;
    int n_fail = 0;

    // reference history, indexed by clock edge number
    logic        acc_h  [MAXC];
    logic [31:0] row_h  [MAXC];
    logic        kill_h [MAXC];
    int          cyc = 0;

    // frame-level model state
    int drain_left = 0;
    int frame_pos  = 0;
    bit feeding    = 0;

    function automatic logic [31:0] mkrow(input int b);
        return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
    endfunction

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %0h expected %0h", name, c, act, expv);
        end
    endtask

    // Apply one cycle of inputs, predict the outputs after the coming edge.
    task automatic step(input logic r, input logic it, input logic v, input logic [31:0] rows);
        logic rdy, acc, ok;
        int   a;
        exp_t e;
        rst       = r;
        interrupt = it;
        in_valid  = v;
        {row_3, row_2, row_1, row_0} = rows;
        #1;
        rdy = !r && !it && (drain_left == 0);
        chk("in_ready", cyc, 32'(in_ready), 32'(rdy));
        acc = v && rdy;
        acc_h[cyc]  = acc;
        row_h[cyc]  = rows;
        kill_h[cyc] = r || it;

        e     = '0;
        e.cyc = cyc;
        e.fl  = acc && (frame_pos == N - 1);
        if (r) begin
            drain_left = 0; frame_pos = 0; feeding = 0;
        end else if (it) begin
            e.fa = (frame_pos != 0) || feeding;
            drain_left = N; frame_pos = 0; feeding = 0;
        end else if (drain_left > 0) begin
            drain_left--;
        end else if (acc) begin
            frame_pos = (frame_pos + 1) % N;
            feeding   = 1;
        end else if (frame_pos != 0) begin
            e.fa = 1;
            drain_left = N; frame_pos = 0; feeding = 0;
        end else begin
            feeding = 0;
        end

        // column j after this edge carries the row accepted j edges ago,
        // unless a reset or interrupt edge flushed it on the way
        for (int j = 0; j < N; j++) begin
            a  = cyc - j;
            ok = 1'b0;
            if (a >= 0) begin
                ok = acc_h[a];
                for (int t = a + 1; t <= cyc; t++) if (kill_h[t]) ok = 1'b0;
            end
            if (ok) begin
                e.cols[j*8 +: 8] = row_h[a][j*8 +: 8];
                e.cv[j] = 1'b1;
            end
        end
        e.ov = e.cv[0];
        exp_q.push_back(e);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic send(input logic [31:0] rows);
        step(1'b0, 1'b0, 1'b1, rows);
    endtask

    // monitor: pops one prediction per edge and compares every output
    initial begin
        exp_t        e;
        logic [31:0] ac;
        logic [3:0]  av;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ac = {col_3, col_2, col_1, col_0};
                av = {col_valid_3, col_valid_2, col_valid_1, col_valid_0};
                for (int j = 0; j < N; j++) begin
                    chk($sformatf("col_%0d", j), e.cyc, 32'(ac[j*8 +: 8]), 32'(e.cols[j*8 +: 8]));
                    chk($sformatf("col_valid_%0d", j), e.cyc, 32'(av[j]), 32'(e.cv[j]));
                end
                chk("out_valid", e.cyc, 32'(out_valid), 32'(e.ov));
                chk("frame_last", e.cyc, 32'(frame_last), 32'(e.fl));
                chk("frame_abort", e.cyc, 32'(frame_abort), 32'(e.fa));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // reset
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'hdeadbeef);

        // one full frame of known rows, then back to idle
        for (int i = 0; i < 4; i++) send(mkrow(4 * i + 1));
        idle(5);

        // two back-to-back frames
        for (int i = 0; i < 8; i++) send($urandom);
        idle(5);

        // gap after two rows: abort and drain, rows offered during drain are refused
        send($urandom);
        send($urandom);
        idle(1);
        for (int i = 0; i < 4; i++) send($urandom);
        for (int i = 0; i < 4; i++) send($urandom);
        idle(4);

        // interrupt on the third row of a frame
        send($urandom);
        send($urandom);
        step(1'b0, 1'b1, 1'b1, $urandom);
        for (int i = 0; i < 5; i++) send($urandom);
        for (int i = 0; i < 3; i++) send($urandom);
        idle(4);

        // reset mid-frame with a row offered
        send($urandom);
        send($urandom);
        step(1'b1, 1'b0, 1'b1, $urandom);
        for (int i = 0; i < 4; i++) send($urandom);
        idle(4);

        // interrupt coinciding with a mid-frame gap
        send($urandom);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        idle(6);

        // quiet idle
        idle(10);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 99) < 85),
                 $urandom);
        end
        idle(8);

        @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/wxyz_skew_feed_nxn.md
Name: wxyz_skew_feed_nxn

Overview:
Transmit-side feeder for the nxn systolic array and the downstream wxyz accumulator. It accepts one input row per cycle over a valid/ready handshake and frames rows into tiles of arraySize rows. It emits each row with a diagonal skew: column j is delayed j+1 cycles. Its out_valid is the frame-continuous valid that drives the accumulator's valid input, and its row counter stays in lockstep with the accumulator's counter.

Parameters:
arraySize, 4, rows per frame and number of columns.
inputBits, 8, width of each row element.
addressWidth, 2, width of the row counter; equals clog2(arraySize).

Ports:
clk  input  1  clock.
rst  input  1  synchronous active-high reset.
interrupt  input  1  abort the current frame and flush the skew pipeline.
in_valid  input  1  row_* holds a valid row.
in_ready  output  1  feeder accepts a row this cycle.
row_0..row_3  input  inputBits each  input row elements; element j goes to column j.
out_valid  output  1  registered accept strobe, aligned to col_0; drives the accumulator valid.
col_0..col_3  output  inputBits each  skewed column data to the array.
col_valid_0..col_valid_3  output  1 each  per-column valid, skewed identically to the data.
frame_last  output  1  pulse aligned with out_valid for the last row of a frame.
frame_abort  output  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Accept = in_valid && in_ready. in_ready is combinational from state: 1 in IDLE and FEED, 0 in DRAIN, 0 while rst is high.
- Row counter: addressWidth bits. Increments on accept. Wraps to 0 after the accept at arraySize-1. Forced to 0 on interrupt, abort or rst.
- Skew pipeline:
  - col_j is element j of an accepted row, delayed exactly j+1 cycles. Stage 0 is one register; column j is a chain of j+1 registers.
  - col_valid_j is the accept strobe delayed by the same j+1 cycles.
  - On a non-accept cycle a zero bubble enters: data 0, valid 0.
  - out_valid equals col_valid_0.
- frame_last: registered (counter == arraySize-1 && accept), so it is aligned with out_valid.
- FSM states:
  - IDLE: no frame in progress. Accept with counter 0 -> FEED (for arraySize==1, stay in IDLE).
  - FEED: frame in progress.
    - Accept at counter arraySize-1 with in_valid -> FEED; a back-to-back frame is allowed with no bubble.
    - Accept at counter arraySize-1 with no further in_valid next cycle -> IDLE.
    - in_valid low while counter != 0 (gap mid-frame) -> abort: frame_abort=1 next cycle, counter->0, go to DRAIN. This rule exists because the accumulator clears on any valid-low cycle, so a partial frame is meaningless.
  - DRAIN: in_ready=0 for exactly arraySize cycles, timed by a drain counter. Zero bubbles flush the skew chains. Then -> IDLE.
- interrupt:
  - Any state: next cycle all skew registers and col_valid_* are 0, counter is 0, state is DRAIN, and the drain counter restarts.
  - A row presented in the same cycle as interrupt is not accepted; in_ready is forced to 0 that cycle.
  - interrupt has priority over accept and gap abort.
  - frame_abort pulses only if a frame was in progress (counter != 0 or state FEED).
- Simultaneous gap and interrupt: treat as interrupt; a single frame_abort pulse.
- Reset (synchronous, highest priority):
  - state IDLE, counter 0, drain counter 0.
  - All col_*, col_valid_*, out_valid, frame_last and frame_abort are 0.
  - Reset mid-frame discards all in-flight data with no abort pulse.
- Widths: data is passed through unmodified with no arithmetic. The counter compare uses arraySize-1 truncated to addressWidth.

Test Plan:
1. Reset, then 4 consecutive accepts of rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} -> col_0 = 1,5,9,13 on cycles 1-4; col_3 = 4,8,12,16 on cycles 4-7; out_valid high on cycles 1-4; frame_last on cycle 4; return to IDLE.
2. 8 back-to-back rows -> out_valid high for 8 continuous cycles, frame_last on cycles 4 and 8, in_ready never drops.
3. Gap after 2 rows of a frame -> frame_abort pulses once, in_ready low for 4 cycles, col_valid_* all 0 after 4 cycles, next accepted row starts at counter 0.
4. interrupt during the 3rd row while in_valid=1 -> that row is not accepted; next cycle all col_valid_*=0 and col_*=0; in_ready=0 for 4 cycles; frame_abort=1.
5. rst asserted mid-frame with in_valid=1 -> next cycle all outputs 0, in_ready=0 during rst, then in_ready=1 and no frame_abort pulse.
6. Idle in_valid=0 for 10 cycles -> outputs stay 0, in_ready=1, no frame_abort.
